wbm_cmd_master: RTL and testbench
=================================

// Module: wbm_cmd_master
// PURPOSE
//  Single-transaction pipelined-Wishbone bus master (initiator). Accepts one
//  read/write command at a time on a valid/ready port, drives CYC/STB until
//  accepted, waits for ACK/ERR, returns a one-cycle response pulse. Sits in
//  front of peripheral slaves (LED/button/switch I/O etc.) for debug/test
//  access. Aborts any cycle that receives neither ACK nor ERR in time.
// PARAMETERS
//  AW         30  address width (word address)
//  DW         32  data width; sel width is DW/8
//  LGTIMEOUT  10  abort after 2^LGTIMEOUT cycles of CYC without ACK/ERR
// PORTS
//  i_clk          in   1       system clock
//  i_reset        in   1       synchronous, active-high reset
//  i_cmd_valid    in   1       command present
//  o_cmd_ready    out  1       command accepted when valid&&ready
//  i_cmd_we       in   1       1=write, 0=read
//  i_cmd_addr     in   AW      word address
//  i_cmd_data     in   DW      write data
//  i_cmd_sel      in   DW/8    byte selects
//  o_rsp_valid    out  1       one-cycle response pulse, no backpressure
//  o_rsp_data     out  DW      read data (0 for writes/err/timeout)
//  o_rsp_err      out  1       bus error or timeout
//  o_rsp_timeout  out  1       cycle aborted by timeout
//  o_wb_cyc/o_wb_stb/o_wb_we  out  1  Wishbone controls
//  o_wb_addr      out  AW      o_wb_data out DW; o_wb_sel out DW/8
//  i_wb_stall/i_wb_ack/i_wb_err  in  1;  i_wb_data  in  DW
// BEHAVIOUR
//  - Reset (sync, high): next cycle state=IDLE, cyc=stb=0, rsp_valid=0,
//    rsp_err=rsp_timeout=0, rsp_data=0, counter=0. Commands presented in a
//    reset cycle are not accepted; an in-flight cycle is dropped, no response.
//  - o_cmd_ready = (state==IDLE) && !i_reset.
//  - IDLE: on valid&&ready latch we/addr/data/sel onto o_wb_*, cyc=stb=1 next
//    cycle, counter=0, ->STROBE. o_wb_addr/data/sel/we change only on accept.
//  - STROBE: stb held, o_wb_* constant, while i_wb_stall. First cycle with
//    !i_wb_stall: stb=0 next cycle, ->WAIT.
//  - WAIT: i_wb_ack -> cyc=0, rsp_valid=1, rsp_data=(we?0:i_wb_data), ->IDLE.
//  - i_wb_err in STROBE or WAIT -> cyc=stb=0, rsp_valid=1, rsp_err=1,
//    rsp_data=0, ->IDLE. ERR and ACK same cycle: ERR wins.
//  - ACK/ERR sampled in IDLE (cyc=0) or in STROBE while stalled: ACK ignored.
//  - Counter increments every cycle cyc=1 (0 in first cycle). If counter==
//    2^LGTIMEOUT-1 and no ACK/ERR that cycle: next cycle cyc=stb=0,
//    rsp_valid=1, rsp_err=1, rsp_timeout=1, ->IDLE. CYC therefore high for
//    exactly 2^LGTIMEOUT cycles on timeout; ACK in last counted cycle wins.
//  - rsp_* registered: response in cycle after ACK/ERR, same cycle cyc falls.
//    rsp_err/timeout/data valid only with rsp_valid; cleared otherwise.
//  - Latency: accept T, stb T+1, zero-stall 1-cycle-ack slave ACK T+2,
//    rsp_valid T+3; ready high at T+3, next accept possible at T+3.
//  - Only one transaction outstanding; never raises stb twice per cycle.
// TESTING
//  1 Write we=1 addr=0x10 data=0xA5 sel=0xF at T, slave ack next cycle ->
//    stb high only T+1, rsp_valid T+3, err=0, data=0, cyc low T+3.
//  2 Read addr=0x20, stall 3 cycles, ack 1 later data=0x01020304 -> stb high
//    4 cycles with constant addr/sel, rsp_data=0x01020304, err=0.
//  3 LGTIMEOUT=4, slave silent -> cyc high exactly 16 cycles, then
//    rsp_valid with err=1 timeout=1 data=0; ready high same cycle.
//  4 ACK and ERR same cycle in WAIT -> rsp_err=1, rsp_timeout=0, data=0.
//  5 Reset asserted in WAIT -> cyc=0 next cycle, no rsp_valid, later ack
//    ignored, new command accepted after reset deasserts.
//  6 Two commands back-to-back with valid held -> 2nd accepted in rsp_valid
//    cycle of 1st; stray ack injected while IDLE produces no response.

Source files
------------

// File: rtl/wbm_cmd_master.sv
// Single-transaction pipelined Wishbone master: one command in, one bus cycle out,
// one registered response pulse back. Silent slaves are aborted after 2^LGTIMEOUT cycles.
module wbm_cmd_master #(
    parameter int unsigned AW        = 30,
    parameter int unsigned DW        = 32,
    parameter int unsigned LGTIMEOUT = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    // Command port
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [AW-1:0]     i_cmd_addr,
    input  logic [DW-1:0]     i_cmd_data,
    input  logic [DW/8-1:0]   i_cmd_sel,
    // Response port
    output logic              o_rsp_valid,
    output logic [DW-1:0]     o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_rsp_timeout,
    // Wishbone master port
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [AW-1:0]     o_wb_addr,
    output logic [DW-1:0]     o_wb_data,
    output logic [DW/8-1:0]   o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [DW-1:0]     i_wb_data
);

    localparam int unsigned SW = DW / 8;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StStrobe = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;

    localparam logic [LGTIMEOUT-1:0] CntMax = {LGTIMEOUT{1'b1}};
    localparam logic [LGTIMEOUT-1:0] CntOne = {{(LGTIMEOUT-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        data_q, data_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [LGTIMEOUT-1:0] cnt_q, cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic [DW-1:0]        rsp_data_q, rsp_data_d;

    logic cnt_last;

    assign cnt_last = (cnt_q == CntMax);

    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        addr_d        = addr_q;
        data_d        = data_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_data_d    = '0;

        unique case (state_q)
            StIdle: begin
                // Bus fields are only ever loaded here, so they hold for the whole cycle
                if (i_cmd_valid) begin
                    state_d = StStrobe;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = i_cmd_we;
                    addr_d  = i_cmd_addr;
                    data_d  = i_cmd_data;
                    sel_d   = i_cmd_sel;
                    cnt_d   = '0;
                end
            end

            StStrobe: begin
                cnt_d = cnt_q + CntOne;
                if (i_wb_err) begin
                    state_d     = StIdle;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (cnt_last) begin
                    // ACK cannot legally arrive before the strobe is taken, so only ERR saves us
                    state_d       = StIdle;
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (!i_wb_stall) begin
                    state_d = StWait;
                    stb_d   = 1'b0;
                end
            end

            StWait: begin
                cnt_d = cnt_q + CntOne;
                if (i_wb_err) begin
                    state_d     = StIdle;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (i_wb_ack) begin
                    state_d     = StIdle;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = we_q ? '0 : i_wb_data;
                end else if (cnt_last) begin
                    state_d       = StIdle;
                    cyc_d         = 1'b0;
                    stb_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= StIdle;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    // Bus payload needs no reset: it is qualified by cyc/stb
    always_ff @(posedge i_clk) begin
        we_q   <= we_d;
        addr_q <= addr_d;
        data_q <= data_d;
        sel_q  <= sel_d;
    end

    assign o_cmd_ready   = (state_q == StIdle) && !i_reset;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign o_wb_cyc      = cyc_q;
    assign o_wb_stb      = stb_q;
    assign o_wb_we       = we_q;
    assign o_wb_addr     = addr_q;
    assign o_wb_data     = data_q;
    assign o_wb_sel      = sel_q;

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Directed bench for wbm_cmd_master; the slave side is driven by hand, cycle by cycle.
module tb_wbm_cmd_master;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned LGTIMEOUT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_data;
    logic [DW/8-1:0] cmd_sel;
    logic            rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0]   rsp_data;
    logic            wb_cyc, wb_stb, wb_we;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [DW/8-1:0] wb_sel;
    logic            wb_stall, wb_ack, wb_err;
    logic [DW-1:0]   wb_rdata;

    int checks = 0;
    int failures = 0;
    int ncyc;

    always #5 clk = ~clk;

    wbm_cmd_master #(
        .AW        (AW),
        .DW        (DW),
        .LGTIMEOUT (LGTIMEOUT)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_we      (cmd_we),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_data    (cmd_data),
        .i_cmd_sel     (cmd_sel),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .o_wb_cyc      (wb_cyc),
        .o_wb_stb      (wb_stb),
        .o_wb_we       (wb_we),
        .o_wb_addr     (wb_addr),
        .o_wb_data     (wb_data),
        .o_wb_sel      (wb_sel),
        .i_wb_stall    (wb_stall),
        .i_wb_ack      (wb_ack),
        .i_wb_err      (wb_err),
        .i_wb_data     (wb_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [DW/8-1:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_sel   = sel;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_sel = '0;
        wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = '0;
        send(1'b1, 30'h3FF, 32'hBAD0BAD0, 4'hF);  // must not be accepted during reset
        tick();
        tick();
        check("rst_cyc", wb_cyc, 0);
        check("rst_stb", wb_stb, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ready_low", cmd_ready, 0);
        cmd_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_ready_high", cmd_ready, 1);

        // 1: single write, slave acks the cycle after the strobe
        send(1'b1, 30'h10, 32'hA5, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check("t1_stb", wb_stb, 1);
        check("t1_cyc", wb_cyc, 1);
        check("t1_we", wb_we, 1);
        check("t1_addr", wb_addr, 64'h10);
        check("t1_wdata", wb_data, 64'hA5);
        check("t1_sel", wb_sel, 64'hF);
        check("t1_ready_busy", cmd_ready, 0);
        tick();
        check("t1_stb_drop", wb_stb, 0);
        check("t1_cyc_hold", wb_cyc, 1);
        wb_ack = 1'b1;
        wb_rdata = 32'hFFFF_FFFF;
        tick();
        wb_ack = 1'b0;
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_err", rsp_err, 0);
        check("t1_rsp_data", rsp_data, 0);
        check("t1_cyc_low", wb_cyc, 0);
        check("t1_ready", cmd_ready, 1);
        tick();
        check("t1_rsp_pulse", rsp_valid, 0);

        // 2: read with three stalled strobe cycles; an ACK while stalled is ignored
        send(1'b0, 30'h20, 32'hDEAD, 4'h3);
        wb_stall = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_stb", wb_stb, 1);
            check("t2_addr", wb_addr, 64'h20);
            check("t2_sel", wb_sel, 64'h3);
            check("t2_no_rsp", rsp_valid, 0);
            wb_ack = (i == 1);
            if (i == 3) wb_stall = 1'b0;
            tick();
        end
        check("t2_stb_drop", wb_stb, 0);
        check("t2_cyc_hold", wb_cyc, 1);
        wb_ack = 1'b1;
        wb_rdata = 32'h01020304;
        tick();
        wb_ack = 1'b0;
        wb_rdata = '0;
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_rsp_data", rsp_data, 64'h01020304);
        check("t2_rsp_err", rsp_err, 0);
        tick();

        // 3: silent slave, abort after exactly 2^LGTIMEOUT cycles of CYC
        send(1'b1, 30'h50, 32'h1234, 4'hF);
        tick();
        cmd_valid = 1'b0;
        ncyc = 0;
        while (wb_cyc === 1'b1 && ncyc < 40) begin
            check("t3_no_early_rsp", rsp_valid, 0);
            ncyc++;
            tick();
        end
        check("t3_cyc_cycles", ncyc, 16);
        check("t3_rsp_valid", rsp_valid, 1);
        check("t3_rsp_err", rsp_err, 1);
        check("t3_rsp_timeout", rsp_timeout, 1);
        check("t3_rsp_data", rsp_data, 0);
        check("t3_ready", cmd_ready, 1);
        tick();
        check("t3_timeout_clear", rsp_timeout, 0);

        // 4: ACK and ERR together, ERR wins
        send(1'b0, 30'h60, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tick();
        wb_ack = 1'b1;
        wb_err = 1'b1;
        wb_rdata = 32'hCAFE_F00D;
        tick();
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_rdata = '0;
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_err", rsp_err, 1);
        check("t4_rsp_timeout", rsp_timeout, 0);
        check("t4_rsp_data", rsp_data, 0);
        tick();

        // 5: reset during WAIT drops the cycle without a response
        send(1'b0, 30'h70, 32'h0, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t5_in_wait", wb_cyc, 1);
        reset = 1'b1;
        tick();
        check("t5_cyc_drop", wb_cyc, 0);
        check("t5_no_rsp", rsp_valid, 0);
        check("t5_ready_in_rst", cmd_ready, 0);
        reset = 1'b0;
        wb_ack = 1'b1;
        wb_rdata = 32'h9999;
        tick();
        wb_ack = 1'b0;
        check("t5_late_ack", rsp_valid, 0);
        send(1'b0, 30'h30, 32'h0, 4'h1);
        check("t5_ready_after", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("t5_new_stb", wb_stb, 1);
        check("t5_new_addr", wb_addr, 64'h30);
        tick();
        wb_ack = 1'b1;
        wb_rdata = 32'h55;
        tick();
        wb_ack = 1'b0;
        check("t5_rsp_valid", rsp_valid, 1);
        check("t5_rsp_data", rsp_data, 64'h55);

        // 6: back-to-back commands with valid held, then a stray ACK in IDLE
        send(1'b1, 30'h40, 32'h11, 4'hF);
        tick();
        send(1'b0, 30'h44, 32'h22, 4'hC);
        check("t6_a_addr", wb_addr, 64'h40);
        check("t6_a_we", wb_we, 1);
        tick();
        check("t6_a_addr_hold", wb_addr, 64'h40);
        check("t6_b_not_taken", cmd_ready, 0);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("t6_a_rsp", rsp_valid, 1);
        check("t6_ready_in_rsp", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("t6_b_stb", wb_stb, 1);
        check("t6_b_addr", wb_addr, 64'h44);
        check("t6_b_we", wb_we, 0);
        check("t6_b_sel", wb_sel, 64'hC);
        check("t6_b_no_rsp", rsp_valid, 0);
        tick();
        wb_ack = 1'b1;
        wb_rdata = 32'h77;
        tick();
        wb_ack = 1'b0;
        check("t6_b_rsp", rsp_valid, 1);
        check("t6_b_data", rsp_data, 64'h77);
        tick();
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        check("t6_stray_ack", rsp_valid, 0);
        tick();
        check("t6_stray_ack2", rsp_valid, 0);
        check("t6_idle_cyc", wb_cyc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
